// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with one-byte transmit queue
//
// Purpose: byte-oriented SPI target. The external initiator's cs/clk/mosi are
// synchronized into raw_clk, and edges are detected after synchronization. The
// received bytes are posted to rx_data with a sticky ready flag and an overrun
// flag. One transmit byte may be queued; DEFAULT_TX is sent when none is queued.
//
// Ports:
//   raw_clk        sole clock, rising edge
//   reset          synchronous active-low reset
//   spi_cs         chip select, active-low, asynchronous
//   spi_clk        serial clock, mode 0, asynchronous
//   spi_mosi       serial data in, MSB first
//   spi_miso       serial data out, MSB first (0 when not selected)
//   spi_miso_oe    miso output enable, 1 while selected
//   tx_data        byte to queue for transmission
//   tx_strobe      one-cycle request to queue tx_data
//   tx_busy        queued byte not yet loaded into the shifter
//   rx_data        last complete received byte
//   rx_ready       sticky new-byte flag
//   rx_ready_clear one-cycle clear of rx_ready and rx_overrun
//   rx_overrun     sticky, byte completed while rx_ready was still set
//   selected       state machine is in ACTIVE
module spi_responder #(
  parameter logic [7:0] DEFAULT_TX = 8'hff
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       rx_overrun,
  output logic       selected
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  state_t     state_next;

  logic       cs_s1, cs_s2, cs_s3;
  logic       clk_s1, clk_s2, clk_s3;
  logic       mosi_s1, mosi_s2;

  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] tx_q;

  logic       cs_fall, cs_rise, clk_rise, clk_fall;
  logic       enter, leave;
  logic       shift_rise, shift_fall;
  logic       load, byte_done;

  // Edge detection compares the second and third synchronizer stages.
  assign cs_fall  =  cs_s3  & ~cs_s2;
  assign cs_rise  = ~cs_s3  &  cs_s2;
  assign clk_rise = ~clk_s3 &  clk_s2;
  assign clk_fall =  clk_s3 & ~clk_s2;

  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter      = 1'b0;
    leave      = 1'b0;
    shift_rise = 1'b0;
    shift_fall = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          enter      = 1'b1;
        end
      end
      ACTIVE: begin
        // A deselect takes priority over any clock edge seen in the same cycle.
        if (cs_rise) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else begin
          shift_rise = clk_rise;
          shift_fall = clk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
    // The shifter takes a fresh byte on selection and on the falling edge
    // that follows the eighth rising edge (counter back at 0).
    load      = enter | (shift_fall & (bit_cnt == 3'd0));
    byte_done = shift_rise & (bit_cnt == 3'd7);
  end

  assign selected    = (state == ACTIVE);
  assign spi_miso_oe = selected;
  assign spi_miso    = selected & tx_shift[7];

  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      cs_s1      <= 1'b1;
      cs_s2      <= 1'b1;
      cs_s3      <= 1'b1;
      clk_s1     <= 1'b0;
      clk_s2     <= 1'b0;
      clk_s3     <= 1'b0;
      mosi_s1    <= 1'b0;
      mosi_s2    <= 1'b0;
      bit_cnt    <= 3'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      tx_q       <= 8'h00;
      tx_busy    <= 1'b0;
      rx_data    <= 8'h00;
      rx_ready   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      clk_s1  <= spi_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;

      if (enter || leave) begin
        bit_cnt <= 3'd0;
      end else if (shift_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s2};
      end

      if (load) begin
        tx_shift <= tx_busy ? tx_q : DEFAULT_TX;
      end else if (shift_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // A strobe is accepted when the queue is empty or is being emptied
      // this very cycle; the old byte has already gone to the shifter above.
      if (tx_strobe && (!tx_busy || load)) begin
        tx_q    <= tx_data;
        tx_busy <= 1'b1;
      end else if (load) begin
        tx_busy <= 1'b0;
      end

      // Completion beats a simultaneous clear; clear also drops overrun.
      if (byte_done) begin
        rx_data  <= {rx_shift[6:0], mosi_s2};
        rx_ready <= 1'b1;
      end else if (rx_ready_clear) begin
        rx_ready <= 1'b0;
      end

      if (byte_done && rx_ready && !rx_ready_clear) begin
        rx_overrun <= 1'b1;
      end else if (rx_ready_clear) begin
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - self-checking bench for spi_responder
module tb_spi_responder;

  logic       raw_clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear = 1'b0;
  logic       rx_overrun;
  logic       selected;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  spi_responder #(.DEFAULT_TX(8'hff)) dut (
    .raw_clk(raw_clk),
    .reset(reset),
    .spi_cs(spi_cs),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data),
    .tx_strobe(tx_strobe),
    .tx_busy(tx_busy),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_ready_clear(rx_ready_clear),
    .rx_overrun(rx_overrun),
    .selected(selected)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic strobe_tx(input logic [7:0] d);
    @(negedge raw_clk);
    tx_data   = d;
    tx_strobe = 1'b1;
    @(negedge raw_clk);
    tx_strobe = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge raw_clk);
    rx_ready_clear = 1'b1;
    @(negedge raw_clk);
    rx_ready_clear = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge raw_clk);
    spi_cs = 1'b0;
    idle_cycles(8);
  endtask

  task automatic cs_high();
    @(negedge raw_clk);
    spi_cs = 1'b1;
    idle_cycles(8);
  endtask

  // Initiator side: nbits MSB-first bits at raw_clk/8. miso is sampled just
  // before each rising edge. clr_end pulses rx_ready_clear on exactly the
  // cycle the responder registers the eighth rising edge (3rd edge after pin).
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit clr_end,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      idle_cycles(4);
      mi[i]   = spi_miso;
      spi_clk = 1'b1;
      if (clr_end && i == 0) begin
        idle_cycles(2);
        rx_ready_clear = 1'b1;
        idle_cycles(1);
        rx_ready_clear = 1'b0;
        idle_cycles(1);
      end else begin
        idle_cycles(4);
      end
      spi_clk = 1'b0;
    end
    idle_cycles(4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_cycles(3);
    n_checks++;
    if ({selected, spi_miso, spi_miso_oe, tx_busy, rx_ready, rx_overrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got sel/miso/oe/busy/rdy/ovr=%b required 000000",
               {selected, spi_miso, spi_miso_oe, tx_busy, rx_ready, rx_overrun});
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    reset = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_basic();
    logic [7:0] mi, e;
    strobe_tx(8'hA5);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_set: got %b required 1", tx_busy);
    end
    cs_low();
    n_checks++;
    if (spi_miso_oe !== 1'b1 || selected !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_selected: got oe=%b sel=%b required 1 1", spi_miso_oe, selected);
    end
    spi_bits(8'h3C, 8, 1'b0, mi);
    e = exp_miso_q.pop_front();
    n_checks++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL basic_miso: got %h required %h", mi, e);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx_data !== e || rx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rx: got data=%h rdy=%b busy=%b required %h 1 0",
               rx_data, rx_ready, tx_busy, e);
    end
    cs_high();
    pulse_clear();
  endtask

  task automatic test_default();
    logic [7:0] mi, e;
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h02);
    cs_low();
    for (int b = 1; b <= 2; b++) begin
      spi_bits(8'(b), 8, 1'b0, mi);
      e = exp_miso_q.pop_front();
      n_checks++;
      if (mi !== e) begin
        n_fail++;
        $display("FAIL default_miso_byte%0d: got %h required %h", b, mi, e);
      end
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx_data !== e || rx_ready !== 1'b1 || rx_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL default_overrun: got data=%h rdy=%b ovr=%b required %h 1 1",
               rx_data, rx_ready, rx_overrun, e);
    end
    cs_high();
    pulse_clear();
    n_checks++;
    if (rx_ready !== 1'b0 || rx_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flags: got rdy=%b ovr=%b required 0 0", rx_ready, rx_overrun);
    end
  endtask

  task automatic test_queue_mid();
    logic [7:0] mi, e;
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'h11);
    cs_low();
    strobe_tx(8'h11);
    strobe_tx(8'h22);
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL queue_busy: got %b required 1", tx_busy);
    end
    for (int b = 1; b <= 2; b++) begin
      spi_bits(8'h40 + 8'(b), 8, 1'b0, mi);
      e = exp_miso_q.pop_front();
      n_checks++;
      if (mi !== e) begin
        n_fail++;
        $display("FAIL queue_miso_byte%0d: got %h required %h", b, mi, e);
      end
    end
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL queue_busy_clear: got %b required 0", tx_busy);
    end
    cs_high();
    pulse_clear();
  endtask

  task automatic test_abort();
    logic [7:0] mi, e;
    bit oe_dropped;
    cs_low();
    spi_bits(8'hF0, 5, 1'b0, mi);
    @(negedge raw_clk);
    spi_cs = 1'b1;
    oe_dropped = 1'b0;
    for (int i = 0; i < 4 && !oe_dropped; i++) begin
      @(posedge raw_clk);
      #1;
      if (spi_miso_oe === 1'b0) oe_dropped = 1'b1;
    end
    n_checks++;
    if (!oe_dropped) begin
      n_fail++;
      $display("FAIL abort_oe: got oe=%b after 4 cycles required 0", spi_miso_oe);
    end
    idle_cycles(8);
    n_checks++;
    if (rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rx_ready: got %b required 0", rx_ready);
    end
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h96);
    cs_low();
    spi_bits(8'h96, 8, 1'b0, mi);
    e = exp_miso_q.pop_front();
    n_checks++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL abort_next_miso: got %h required %h", mi, e);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx_data !== e || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next_rx: got data=%h rdy=%b required %h 1", rx_data, rx_ready, e);
    end
    cs_high();
    pulse_clear();
  endtask

  task automatic test_clear_collision();
    logic [7:0] mi, e;
    exp_rx_q.push_back(8'hC3);
    cs_low();
    spi_bits(8'h81, 8, 1'b0, mi);
    spi_bits(8'hC3, 8, 1'b1, mi);
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx_data !== e || rx_ready !== 1'b1 || rx_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_collision: got data=%h rdy=%b ovr=%b required %h 1 0",
               rx_data, rx_ready, rx_overrun, e);
    end
    cs_high();
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, e;
    strobe_tx(8'h77);
    exp_miso_q.push_back(8'h5A);
    exp_rx_q.push_back(8'h5A);
    cs_low();
    spi_bits(8'hE7, 8, 1'b0, mi);
    spi_bits(8'hFF, 3, 1'b0, mi);
    @(negedge raw_clk);
    reset  = 1'b0;
    spi_cs = 1'b1;
    @(posedge raw_clk);
    #1;
    n_checks++;
    if ({selected, spi_miso, spi_miso_oe, tx_busy, rx_ready, rx_overrun} !== 6'b0
        || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got sel/miso/oe/busy/rdy/ovr=%b data=%h required 000000 00",
               {selected, spi_miso, spi_miso_oe, tx_busy, rx_ready, rx_overrun}, rx_data);
    end
    @(negedge raw_clk);
    reset = 1'b1;
    idle_cycles(8);
    strobe_tx(8'h5A);
    cs_low();
    spi_bits(8'h5A, 8, 1'b0, mi);
    e = exp_miso_q.pop_front();
    n_checks++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL reset_mid_miso: got %h required %h", mi, e);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx_data !== e || rx_ready !== 1'b1 || rx_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rx: got data=%h rdy=%b ovr=%b required %h 1 0",
               rx_data, rx_ready, rx_overrun, e);
    end
    cs_high();
    n_checks++;
    if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_miso: got miso=%b oe=%b required 0 0", spi_miso, spi_miso_oe);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default();
    test_queue_mid();
    test_abort();
    test_clear_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter DEFAULT_TX, 8'hff: byte shifted out when no transmit byte is queued at a byte boundary.
REQ-002 Port raw_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 Port reset  input  1  reset, synchronous, active-low: 0 sampled on a raw_clk edge resets the block.
REQ-004 Port spi_cs  input  1  chip select from external initiator, active-low, asynchronous to raw_clk.
REQ-005 Port spi_clk  input  1  serial clock from initiator, asynchronous, mode 0 (CPOL=0, CPHA=0).
REQ-006 Port spi_mosi  input  1  serial data in, MSB first.
REQ-007 Port spi_miso  output  1  serial data out, MSB first.
REQ-008 Port spi_miso_oe  output  1  miso tri-state enable, 1 only while selected.
REQ-009 Port tx_data  input  8  byte to queue for transmission.
REQ-010 Port tx_strobe  input  1  one-cycle request to queue tx_data.
REQ-011 Port tx_busy  output  1  1 while a queued byte has not yet been loaded into the shifter.
REQ-012 Port rx_data  output  8  last complete received byte.
REQ-013 Port rx_ready  output  1  sticky flag, new byte in rx_data.
REQ-014 Port rx_ready_clear  input  1  one-cycle clear of rx_ready.
REQ-015 Port rx_overrun  output  1  sticky, byte completed while rx_ready=1; cleared only by rx_ready_clear.
REQ-016 Port selected  output  1  1 while the state machine is in ACTIVE.

Function
REQ-017 spi_cs, spi_clk, spi_mosi SHALL each pass a 2-flop synchronizer; a third flop on cs and clk SHALL provide edge detection (pin-to-detect latency 3 raw_clk cycles).
REQ-018 Supported spi_clk SHALL be at most raw_clk/8, each phase at least 4 raw_clk cycles; faster clocks are out of scope.
REQ-019 States SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs falling edge, ACTIVE->IDLE on synchronized cs rising edge.
REQ-020 On entering ACTIVE: tx shifter loaded from queued byte if tx_busy=1 (tx_busy then cleared same cycle), else DEFAULT_TX; bit counter (3 bits) cleared; spi_miso_oe=1; spi_miso = shifter[7].
REQ-021 On synchronized clk rising edge in ACTIVE: rx shifter <= {rx shifter[6:0], mosi_sync}; bit counter increments, wrapping 7->0.
REQ-022 When the rising edge takes the counter from 7 to 0: rx_data <= completed byte, rx_ready <= 1; if rx_ready was already 1 and rx_ready_clear not asserted that cycle, rx_overrun <= 1.
REQ-023 On synchronized clk falling edge in ACTIVE: if counter=0, tx shifter reloads per REQ-020 rule (queued byte or DEFAULT_TX); otherwise tx shifter shifts left one bit.
REQ-024 spi_miso SHALL always equal tx shifter[7] while ACTIVE; 0 in IDLE.
REQ-025 cs rising edge mid-byte: partial byte discarded, rx_data/rx_ready unchanged, counter cleared, spi_miso_oe=0 next cycle; queued tx byte retained.
REQ-026 clk edges seen in IDLE SHALL be ignored.
REQ-027 tx_strobe with tx_busy=0: tx_data latched, tx_busy <= 1. tx_strobe with tx_busy=1: ignored, queued byte unchanged.
REQ-028 tx_strobe in the same cycle the shifter consumes the queue: consume old byte first, then accept new one (tx_busy stays 1).
REQ-029 rx_ready_clear and byte completion in the same cycle: set wins (rx_ready stays 1, overrun not set).
REQ-030 rx_ready_clear also clears rx_overrun.

Reset
REQ-031 While reset=0 at a raw_clk edge: state IDLE, spi_miso=0, spi_miso_oe=0, rx_data=8'h00, rx_ready=0, rx_overrun=0, tx_busy=0, selected=0, counter and shifters 0, synchronizer flops 1 for cs and 0 for clk/mosi.
REQ-032 Reset asserted mid-transfer SHALL abort immediately; after release the block SHALL wait for a fresh cs falling edge before shifting.

Verification
REQ-033 Queue 8'hA5, assert cs, initiator sends 8'h3C at raw_clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_ready=1, tx_busy=0.
REQ-034 No byte queued, two-byte transfer 8'h01,8'h02 -> miso returns 8'hFF,8'hFF; rx_data=8'h02 after second byte, rx_overrun=1 (no clear between).
REQ-035 Queue 8'h11 during byte 1 of a 2-byte transfer -> byte 2 on miso is 8'h11; second strobe with 8'h22 while busy ignored.
REQ-036 cs deasserted after 5 bits -> rx_ready stays 0, spi_miso_oe=0 within 4 raw_clk cycles, next full transfer received correctly.
REQ-037 rx_ready_clear pulsed on byte-completion cycle -> rx_ready=1, rx_overrun=0.
REQ-038 reset=0 held for one raw_clk edge mid-byte -> all outputs at REQ-031 values; subsequent cs cycle transfers 8'h5A correctly.
